pc_sequencer: RTL and testbench

Program-counter sequencer driving the fetch unit's `Address` input and consuming its `PCAddResult`. Holds the architectural PC, selects next PC from sequential, branch, or jump sources, honours hazard-unit stalls, and flags IF/ID flushes on redirects. Sits at the head of the IF stage, between the hazard/branch logic and the instruction fetch unit.

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : IF-stage program counter. Chooses the next PC from the sequential,
//            branch or jump source, freezes it on stalls and flags flushes.
// Options  : PC_ALIGN_CHECK_EN forces taken targets to word alignment and
//            raises a sticky AlignError when a target is misaligned.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [31:0]            PCAddResult,
    input  logic                   Stall,
    input  logic                   BranchTaken,
    input  logic [31:0]            BranchTarget,
    input  logic                   Jump,
    input  logic [31:0]            JumpTarget,
    output logic [31:0]            Address,
    output logic                   FetchValid,
    output logic                   IF_Flush,
    output logic [STALL_CNT_W-1:0] StallCount,
    output logic                   AlignError
);

    localparam logic [1:0] c_HOLD     = 2'd0;
    localparam logic [1:0] c_RUN      = 2'd1;
    localparam logic [1:0] c_STALL    = 2'd2;
    localparam logic [1:0] c_REDIRECT = 2'd3;

    localparam logic [STALL_CNT_W-1:0] c_CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]             r_state;
    logic [31:0]            r_addr;
    logic                   r_fetch_valid;
    logic                   r_if_flush;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic                   w_redirect;
    logic [31:0]            w_target;
    logic [31:0]            w_load_pc;

    // Branch outranks jump when both resolve in the same cycle.
    always_comb begin
        w_redirect = BranchTaken | Jump;
        w_target   = BranchTaken ? BranchTarget : JumpTarget;
    end

`ifdef PC_ALIGN_CHECK_EN
    logic w_misaligned;
    logic r_align_err;

    always_comb begin
        w_load_pc    = {w_target[31:2], 2'b00};
        w_misaligned = (r_state != c_HOLD) && w_redirect && (w_target[1:0] != 2'b00);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_align_err <= 1'b0;
        end else if (w_misaligned) begin
            r_align_err <= 1'b1;
        end
    end

    assign AlignError = r_align_err;
`else
    always_comb begin
        w_load_pc = w_target;
    end

    assign AlignError = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= c_HOLD;
            r_addr        <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_if_flush    <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            case (r_state)
                // Leaving HOLD keeps RESET_PC so that it becomes the first fetch.
                c_HOLD: begin
                    r_state       <= c_RUN;
                    r_fetch_valid <= 1'b1;
                    r_if_flush    <= 1'b0;
                end
                default: begin
                    if (w_redirect) begin
                        r_state       <= c_REDIRECT;
                        r_addr        <= w_load_pc;
                        r_fetch_valid <= 1'b1;
                        r_if_flush    <= 1'b1;
                    end else if (Stall) begin
                        r_state       <= c_STALL;
                        r_fetch_valid <= 1'b0;
                        r_if_flush    <= 1'b0;
                        if (r_stall_cnt != '1) begin
                            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
                        end
                    end else begin
                        r_state       <= c_RUN;
                        r_addr        <= PCAddResult;
                        r_fetch_valid <= 1'b1;
                        r_if_flush    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign Address    = r_addr;
    assign FetchValid = r_fetch_valid;
    assign IF_Flush   = r_if_flush;
    assign StallCount = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Table-driven scoreboard bench for pc_sequencer, plus a stall
//            counter saturation sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] e_addr;
        logic        e_fv;
        logic        e_fl;
        logic [15:0] e_cnt;
        logic        e_al;
    } vec_t;

    logic        Clk;
    logic        Reset;
    logic [31:0] PCAddResult;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] Address;
    logic        FetchValid;
    logic        IF_Flush;
    logic [15:0] StallCount;
    logic        AlignError;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t tbl[$];
    vec_t sb[$];

    pc_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .STALL_CNT_W (16)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PCAddResult  (PCAddResult),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .Address      (Address),
        .FetchValid   (FetchValid),
        .IF_Flush     (IF_Flush),
        .StallCount   (StallCount),
        .AlignError   (AlignError)
    );

    // Fetch-unit model: sequential next PC is Address + 4.
    assign PCAddResult = Address + 32'd4;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                                input logic [31:0] bt, input logic jmp, input logic [31:0] jt,
                                input logic [31:0] ea, input logic efv, input logic efl,
                                input logic [15:0] ec, input logic eal);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
        v.e_addr = ea; v.e_fv = efv; v.e_fl = efl; v.e_cnt = ec; v.e_al = eal;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        Reset        = v.rst;
        Stall        = v.stall;
        BranchTaken  = v.br;
        BranchTarget = v.bt;
        Jump         = v.jmp;
        JumpTarget   = v.jt;
        sb.push_back(v);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check("Address",    idx, Address,           e.e_addr);
        check("FetchValid", idx, {31'd0, FetchValid}, {31'd0, e.e_fv});
        check("IF_Flush",   idx, {31'd0, IF_Flush},   {31'd0, e.e_fl});
        check("StallCount", idx, {16'd0, StallCount}, {16'd0, e.e_cnt});
        check("AlignError", idx, {31'd0, AlignError}, {31'd0, e.e_al});
    endtask

    initial begin
        logic [31:0] ja;
        logic        al;
`ifdef PC_ALIGN_CHECK_EN
        ja = 32'h0000_0100;
        al = 1'b1;
`else
        ja = 32'h0000_0103;
        al = 1'b0;
`endif
        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        Jump = 1'b0; JumpTarget = '0;

        //            rst stall br  bt            jmp jt            addr          fv fl cnt al
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h8,        0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h8,        0, 0, 2, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h8,        0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hC,        1, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h10,       1, 0, 3, 0));
        tbl.push_back(mk(0, 0, 1, 32'h40,       0, 32'h0,        32'h40,       1, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h44,       1, 0, 3, 0));
        tbl.push_back(mk(0, 1, 1, 32'h80,       1, 32'h200,      32'h80,       1, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h300,      32'h300,      1, 1, 3, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h300,      0, 0, 4, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1, 4, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 4, 0));
        tbl.push_back(mk(0, 0, 1, 32'h500,      0, 32'h0,        32'h500,      1, 1, 4, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h900,      0, 32'h0,        32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h103,      ja,           1, 1, 0, al));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        ja + 32'd4,   1, 0, 0, al));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        ja + 32'd4,   0, 0, 1, al));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Stall long enough to hit the counter ceiling and confirm it holds there.
        Stall = 1'b1;
        repeat (65534) @(posedge Clk);
        #1;
        check("StallCountBelowSat", 100, {16'd0, StallCount}, 32'h0000_FFFE);
        repeat (3) @(posedge Clk);
        #1;
        check("StallCountSat", 101, {16'd0, StallCount}, 32'h0000_FFFF);
        check("StallAddrHeld", 102, Address, 32'h0);
        Stall = 1'b0;
        @(posedge Clk);
        #1;
        check("PostStallAddr", 103, Address, 32'h4);
        check("PostStallCount", 104, {16'd0, StallCount}, 32'h0000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
